// File: rtl/mips_data_memory_pkg.sv
// Shared constants and types for the MIPS data memory slice.
// No logic here; pure definitions.
// Imported by the clear controller and the memory top.
package mips_data_memory_pkg;

    // Default array depth in 32-bit words.
    localparam int DMEM_DEPTH_WORDS = 1024;

    // Bytes per memory word; the low log2(bytes) address bits select a byte.
    localparam int DMEM_WORD_BYTES = 4;

    // Clear/run state encoding.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

    // True when a byte address points at the start of a word.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mips_dmem_clear_ctrl.sv
// Clear sequencer: walks every word after reset, then parks in RUN with ready high.
// Latency: ready rises DEPTH_WORDS edges after the first edge with reset low.
// No backpressure; CPU accesses are simply gated off until ready.
module mips_dmem_clear_ctrl
    import mips_data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Next-state, counter advance and clear-write strobe.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        ready     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // Reset edges must not touch the array, so the strobe is masked by reset.
                clr_we    = ~reset;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH_WORDS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clr_idx = clr_cnt_q;

endmodule

// File: rtl/mips_data_memory.sv
// Word-addressed CPU data memory with combinational read, clocked write, sticky error flags.
// Latency: read is same-cycle; write visible the cycle after its edge.
// No backpressure; accesses while not ready read 0 and drop writes.
module mips_data_memory
    import mips_data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_memory_a,
    input  logic        data_memory_we,
    input  logic [31:0] data_memory_wd,
    output logic [31:0] data_memory_rd,
    output logic        ready,
    output logic        err_misaligned,
    output logic        err_range
);

    localparam int BSEL_W = $clog2(DMEM_WORD_BYTES);

    logic [31:0]       mem [0:DEPTH_WORDS-1];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              aligned;
    logic              wr_ok;
    logic              err_misaligned_q, err_misaligned_d;
    logic              err_range_q, err_range_d;

    mips_dmem_clear_ctrl #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_clear_ctrl (
        .clk     (clk),
        .reset   (reset),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .ready   (ready)
    );

    // Address decode, read mux, write qualification and sticky flag update.
    always_comb begin
        idx              = data_memory_a[ADDR_W+BSEL_W-1:BSEL_W];
        in_range         = (data_memory_a[31:ADDR_W+BSEL_W] == '0);
        aligned          = is_word_aligned(data_memory_a[1:0]);
        wr_ok            = ready & data_memory_we & in_range & aligned;
        data_memory_rd   = 32'h0;
        if (ready && in_range && aligned) begin
            data_memory_rd = mem[idx];
        end
        // Misalignment only matters for writes; range applies to any access once running.
        err_misaligned_d = err_misaligned_q | (ready & data_memory_we & ~aligned);
        err_range_d      = err_range_q | (ready & ~in_range);
    end

    // Array write port: clear sequence has priority, CPU writes only once ready.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= 32'h0;
        end else if (wr_ok) begin
            mem[idx] <= data_memory_wd;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_misaligned_q <= 1'b0;
            err_range_q      <= 1'b0;
        end else begin
            err_misaligned_q <= err_misaligned_d;
            err_range_q      <= err_range_d;
        end
    end

    assign err_misaligned = err_misaligned_q;
    assign err_range      = err_range_q;

endmodule

// File: tb/tb_mips_data_memory.sv
// Bench for mips_data_memory at DEPTH_WORDS=16.
// Inputs change 1ns after posedge; outputs are sampled 3ns after posedge.
// Expected read data is queued when stimulus is applied and popped at sampling.
module tb_mips_data_memory;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err_mis;
    logic        err_rng;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model[DEPTH];

    mips_data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_memory_a  (a),
        .data_memory_we (we),
        .data_memory_wd (wd),
        .data_memory_rd (rd),
        .ready          (ready),
        .err_misaligned (err_mis),
        .err_range      (err_rng)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one access and queue the read data it must produce this cycle.
    task automatic drive(input logic [31:0] aa, input logic w, input logic [31:0] d,
                         input logic [31:0] exp_rd);
        a  = aa;
        we = w;
        wd = d;
        exp_q.push_back(exp_rd);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 32'h0);
        step();
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL reset_rd got %h want %h", rd, e); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++;
        if (err_mis !== 1'b0 || err_rng !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %b%b want 00", err_mis, err_rng);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_clear();
        logic [31:0] e;
        for (int n = 0; n < 18; n++) begin
            if (n == 3) drive(32'h8, 1'b1, 32'hDEADBEEF, 32'h0);
            else if (n < DEPTH) drive(32'(n * 4), 1'b0, 32'h0, 32'h0);
            else drive(32'h8, 1'b0, 32'h0, 32'h0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (ready !== (n >= DEPTH)) begin
                errors++; $display("FAIL clear_ready n=%0d got %b want %b", n, ready, (n >= DEPTH));
            end
            checks++;
            if (rd !== e) begin errors++; $display("FAIL clear_rd n=%0d got %h want %h", n, rd, e); end
            step();
        end
        checks++;
        if (err_mis !== 1'b0 || err_rng !== 1'b0) begin
            errors++; $display("FAIL clear_flags got %b%b want 00", err_mis, err_rng);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic test_rdw();
        logic [31:0] e;
        drive(32'h3C, 1'b1, 32'h12345678, model[15]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL rdw_old got %h want %h", rd, e); end
        model[15] = 32'h12345678;
        step();
        drive(32'h3C, 1'b0, 32'h0, model[15]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL rdw_new got %h want %h", rd, e); end
        step();
    endtask

    task automatic test_misaligned();
        logic [31:0] e;
        drive(32'h6, 1'b1, 32'hFFFFFFFF, 32'h0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL mis_rd got %h want %h", rd, e); end
        step();
        we = 1'b0;
        #2;
        checks++;
        if (err_mis !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", err_mis); end
        checks++;
        if (err_rng !== 1'b0) begin errors++; $display("FAIL mis_rng got %b want 0", err_rng); end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] ra;
            ra = (k == 0) ? 32'h4 : (k == 1) ? 32'h8 : 32'h6;
            drive(ra, 1'b0, 32'h0, (k == 2) ? 32'h0 : model[ra[5:2]]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL mis_word a=%h got %h want %h", ra, rd, e); end
        end
        step();
    endtask

    task automatic test_range();
        logic [31:0] e;
        drive(32'h40, 1'b1, 32'hAAAA5555, 32'h0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL rng_rd got %h want %h", rd, e); end
        step();
        drive(32'h0, 1'b0, 32'h0, model[0]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (err_rng !== 1'b1) begin errors++; $display("FAIL rng_flag got %b want 1", err_rng); end
        checks++;
        if (rd !== e) begin errors++; $display("FAIL rng_alias got %h want %h", rd, e); end
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (err_rng !== 1'b1 || err_mis !== 1'b1) begin
            errors++; $display("FAIL rng_hold got %b%b want 11", err_mis, err_rng);
        end
        // Both errors again in one access: flags must stay set.
        drive(32'h41, 1'b1, 32'h1, 32'h0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL both_rd got %h want %h", rd, e); end
        step();
        drive(32'h0, 1'b0, 32'h0, model[0]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (err_rng !== 1'b1 || err_mis !== 1'b1 || rd !== e) begin
            errors++; $display("FAIL both_hold got %b%b rd %h want 11 rd %h", err_mis, err_rng, rd, e);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            drive(32'(i * 4), 1'b1, v, model[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL b2b_wr i=%0d got %h want %h", i, rd, e); end
            model[i] = v;
            step();
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            drive(32'(i * 4), 1'b0, 32'h0, model[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL b2b_rd i=%0d got %h want %h", i, rd, e); end
            step();
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] e;
        int          budget;
        drive(32'h10, 1'b1, 32'hCAFEF00D, model[4]);
        #2;
        void'(exp_q.pop_front());
        step();
        model[4] = 32'hCAFEF00D;
        drive(32'h10, 1'b0, 32'h0, model[4]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL pre_rst_rd got %h want %h", rd, e); end
        // Reset from RUN starts a second clear.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) step();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reclear_ready got %b want 0", ready); end
        // Reset again on cycle 5 of that clear.
        reset = 1'b1;
        step();
        #2;
        checks++;
        if (err_mis !== 1'b0 || err_rng !== 1'b0) begin
            errors++; $display("FAIL rst_flags got %b%b want 00", err_mis, err_rng);
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        budget = 0;
        while (ready !== 1'b1 && budget < 40) begin
            step();
            budget++;
        end
        checks++;
        if (budget != DEPTH) begin
            errors++; $display("FAIL rst_latency got %0d cycles want %0d", budget, DEPTH);
        end
        drive(32'h10, 1'b0, 32'h0, model[4]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL post_rst_rd got %h want %h", rd, e); end
        step();
    endtask

    initial begin
        reset = 1'b1;
        a     = 32'h0;
        we    = 1'b0;
        wd    = 32'h0;
        #1;
        test_reset();
        test_clear();
        test_rdw();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
